// File: rtl/pwm_capture.sv
// PWM capture: measures the period (rising to rising edge) and high time
// (rising to falling edge) of an asynchronous PWM input, in CLK cycles.
// One result per completed period, flagged by a one-cycle Valid pulse.
// A counter that saturates without seeing an edge sets a sticky Timeout.
module pwm_capture #(
    parameter int CntWidth   = 16,
    parameter int SyncStages = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                IN,
    input  logic                Enable,
    output logic [CntWidth-1:0] PeriodOut,
    output logic [CntWidth-1:0] HighOut,
    output logic                Valid,
    output logic                Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic [SyncStages-1:0] r_sync;
    logic                  r_s_d;
    state_t                r_state;
    logic [CntWidth-1:0]   r_cnt;
    logic [CntWidth-1:0]   r_high_latch;
    logic [CntWidth-1:0]   r_period;
    logic [CntWidth-1:0]   r_high;
    logic                  r_valid;
    logic                  r_timeout;

    logic                  w_s;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_cnt_max;
    logic [CntWidth-1:0]   w_cnt_inc;

    assign w_s       = r_sync[SyncStages-1];
    assign w_rise    = w_s & ~r_s_d;
    assign w_fall    = ~w_s & r_s_d;
    assign w_cnt_max = (r_cnt == CntMax);
    assign w_cnt_inc = r_cnt + CntOne;

    // Synchroniser chain for the asynchronous input plus one-cycle edge history.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], IN};
            r_s_d  <= w_s;
        end
    end

    // Measurement FSM: counts cycles, latches high time on fall, publishes on rise.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_high_latch <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!Enable) begin
                // Interrupted period is dropped; results are held.
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_timeout <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Falls here are ignored so the first partial period is discarded.
                        if (w_rise) begin
                            r_cnt   <= CntOne;
                            r_state <= ST_HIGH;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    ST_HIGH: begin
                        if (w_fall) begin
                            r_high_latch <= r_cnt;
                            r_cnt        <= w_cnt_inc;
                            r_state      <= ST_LOW;
                        end else if (w_cnt_max) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            r_period  <= r_cnt;
                            r_high    <= r_high_latch;
                            r_valid   <= 1'b1;
                            r_timeout <= 1'b0;
                            r_cnt     <= CntOne;
                            r_state   <= ST_HIGH;
                        end else if (w_cnt_max) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign PeriodOut = r_period;
    assign HighOut   = r_high;
    assign Valid     = r_valid;
    assign Timeout   = r_timeout;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit instance driven from a table of
// PWM shapes with a timed expectation queue, and an 8-bit instance used for
// the saturation/timeout sequence.
module tb_pwm_capture;

    logic        clk   = 1'b0;
    logic        nrst  = 1'b1;
    logic        in16  = 1'b0;
    logic        en16  = 1'b0;
    logic        in8   = 1'b0;
    logic        en8   = 1'b0;
    logic [15:0] period16, high16;
    logic        valid16, timeout16;
    logic [7:0]  period8, high8;
    logic        valid8, timeout8;

    pwm_capture #(.CntWidth(16), .SyncStages(2)) u_dut16 (
        .CLK(clk), .nRST(nrst), .IN(in16), .Enable(en16),
        .PeriodOut(period16), .HighOut(high16), .Valid(valid16), .Timeout(timeout16)
    );

    pwm_capture #(.CntWidth(8), .SyncStages(2)) u_dut8 (
        .CLK(clk), .nRST(nrst), .IN(in8), .Enable(en8),
        .PeriodOut(period8), .HighOut(high8), .Valid(valid8), .Timeout(timeout8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int p; int h; int when; } exp_t;
    typedef struct { int high; int low; int reps; int exp_p; int exp_h; } vec_t;

    exp_t q[$];
    vec_t vecs[7];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_v8  = 0;
    bit   have_prev = 1'b0;
    int   prev_p = 0;
    int   prev_h = 0;
    int   t0, t1, t2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    // One PWM period on the 16-bit instance; the rise closes the previous period.
    task automatic drive_period(input vec_t v);
        tick();
        if (have_prev) q.push_back('{prev_p, prev_h, cyc + 3});
        in16 = 1'b1;
        prev_p = v.exp_p;
        prev_h = v.exp_h;
        have_prev = 1'b1;
        repeat (v.high - 1) tick();
        tick();
        in16 = 1'b0;
        repeat (v.low - 1) tick();
    endtask

    // Scoreboard: Valid must appear exactly when expected with the expected values.
    always @(negedge clk) begin
        if (q.size() > 0 && cyc == q[0].when) begin
            check("valid16_pulse", {31'd0, valid16}, 32'd1);
            check("period16", {16'd0, period16}, q[0].p);
            check("high16", {16'd0, high16}, q[0].h);
            void'(q.pop_front());
        end else if (valid16 === 1'b1) begin
            check("unexpected_valid16", {31'd0, valid16}, 32'd0);
        end
        if (valid8 === 1'b1) n_v8++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{6,   4,   4, 10,  6};
        vecs[1] = '{2,   8,   3, 10,  2};
        vecs[2] = '{1,   1,   4, 2,   1};
        vecs[3] = '{1,   5,   2, 6,   1};
        vecs[4] = '{200, 100, 2, 300, 200};
        vecs[5] = '{5,   1,   2, 6,   5};
        vecs[6] = '{6,   4,   2, 10,  6};

        // Reset held with the input toggling.
        #3 nrst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            in16 = ~in16;
            in8  = ~in8;
            @(negedge clk);
            check("rst_period16", {16'd0, period16}, 32'd0);
            check("rst_high16", {16'd0, high16}, 32'd0);
            check("rst_valid16", {31'd0, valid16}, 32'd0);
            check("rst_timeout16", {31'd0, timeout16}, 32'd0);
        end
        check("rst_timeout8", {31'd0, timeout8}, 32'd0);
        in16 = 1'b0;
        in8  = 1'b0;
        tick();
        nrst = 1'b1;
        en8  = 1'b1;
        repeat (3) tick();

        // Saturation on the 8-bit instance: input stuck high after a rise.
        in8 = 1'b1;
        t0 = cyc;
        wait_neg(t0 + 257);
        check("sat_before_timeout8", {31'd0, timeout8}, 32'd0);
        wait_neg(t0 + 258);
        check("sat_timeout8", {31'd0, timeout8}, 32'd1);
        check("sat_no_valid8", n_v8, 32'd0);
        tick();
        in8 = 1'b0;
        repeat (5) tick();
        check("timeout8_sticky", {31'd0, timeout8}, 32'd1);
        in8 = 1'b1;
        t1 = cyc;
        repeat (10) tick();
        in8 = 1'b0;
        repeat (10) tick();
        in8 = 1'b1;
        t2 = cyc;
        check("resume_span8", t2 - t1, 32'd20);
        wait_neg(t2 + 2);
        check("resume_timeout8_pre", {31'd0, timeout8}, 32'd1);
        check("resume_no_valid8_pre", n_v8, 32'd0);
        wait_neg(t2 + 3);
        check("resume_valid8", {31'd0, valid8}, 32'd1);
        check("resume_period8", {24'd0, period8}, 32'd20);
        check("resume_high8", {24'd0, high8}, 32'd10);
        check("resume_timeout8_clr", {31'd0, timeout8}, 32'd0);
        tick();
        in8 = 1'b0;
        en8 = 1'b0;

        // Table of PWM shapes on the 16-bit instance.
        en16 = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 7; i++)
            for (int r = 0; r < vecs[i].reps; r++)
                drive_period(vecs[i]);

        // Enable dropped for 3 cycles mid-period.
        tick();
        if (have_prev) q.push_back('{prev_p, prev_h, cyc + 3});
        in16 = 1'b1;
        repeat (4) tick();
        en16 = 1'b0;
        have_prev = 1'b0;
        @(negedge clk);
        check("dis_timeout16", {31'd0, timeout16}, 32'd0);
        check("dis_hold_period16", {16'd0, period16}, 32'd10);
        check("dis_hold_high16", {16'd0, high16}, 32'd6);
        tick();
        in16 = 1'b0;
        tick();
        tick();
        en16 = 1'b1;
        repeat (3) tick();
        for (int r = 0; r < 3; r++) drive_period(vecs[0]);

        // Asynchronous reset in the LOW phase.
        tick();
        nrst = 1'b0;
        #1;
        check("arst_period16", {16'd0, period16}, 32'd0);
        check("arst_high16", {16'd0, high16}, 32'd0);
        check("arst_valid16", {31'd0, valid16}, 32'd0);
        check("arst_timeout16", {31'd0, timeout16}, 32'd0);
        check("arst_queue_empty", q.size(), 32'd0);
        have_prev = 1'b0;
        tick();
        nrst = 1'b1;
        repeat (2) tick();
        for (int r = 0; r < 3; r++) drive_period('{3, 7, 1, 10, 3});
        tick();
        if (have_prev) q.push_back('{prev_p, prev_h, cyc + 3});
        have_prev = 1'b0;
        in16 = 1'b1;
        repeat (6) tick();
        en16 = 1'b0;
        in16 = 1'b0;
        repeat (6) tick();

        check("final_queue_empty", q.size(), 32'd0);
        check("final_timeout16", {31'd0, timeout16}, 32'd0);
        check("final_period16", {16'd0, period16}, 32'd10);
        check("final_high16", {16'd0, high16}, 32'd3);
        check("total_valid8", n_v8, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
